// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC array controller: FSM states, inst bit positions
// and phase-length helpers used to size and terminate the phase counter.
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_EXEC,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int INST_EXEC = 1;
  localparam int INST_LOAD = 0;

  // Long enough for the last execute vector to clear row skew plus column skew.
  function automatic int drain_len(input int rows, input int cols);
    return rows + cols + 1;
  endfunction

  function automatic int cnt_width(input int cw, input int rows, input int cols);
    int w;
    w = $clog2(rows + cols + 2);
    return (cw > w) ? cw : w;
  endfunction

endpackage

// File: rtl/inst_skew.sv
// DEPTH-stage shift-register delay line; tap k is din delayed by k+1 cycles.
// No flow control: shifts every cycle, cleared asynchronously.
module inst_skew #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       din,
  output logic [DEPTH*WIDTH-1:0] taps
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= din;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  always_comb begin
    taps = '0;
    for (int k = 0; k < DEPTH; k++) taps[k*WIDTH +: WIDTH] = stage[k];
  end

endmodule

// File: rtl/mac_array_ctrl.sv
// Systolic MAC array job sequencer: LOAD/GAP/EXEC/DRAIN with skewed row inst and column valids.
// Row-0 inst is combinational from state; each phase waits at entry for l0_ready, then runs blind.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int ROW = 8,
  parameter int COL = 8,
  parameter int CW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            load_en,
  input  logic [CW-1:0]   num_vec,
  input  logic            act_mode_in,
  input  logic            l0_ready,
  output logic [2*ROW-1:0] inst_w,
  output logic [ROW-1:0]  l0_rd,
  output logic            act_mode,
  output logic [COL-1:0]  col_valid,
  output logic            busy,
  output logic            done
);

  localparam int CNTW = cnt_width(CW, ROW, COL);
  localparam logic [CNTW-1:0] COL_LEN   = CNTW'(COL);
  localparam logic [CNTW-1:0] DRAIN_LEN = CNTW'(drain_len(ROW, COL));

  state_t          state, state_n;
  logic [CNTW-1:0] cnt, cnt_n, cnt_inc, exec_len;
  logic [CW-1:0]   nv_q;
  logic            loaded, loaded_n;
  logic            go;
  logic [1:0]      row0_inst;
  logic [2*(ROW-1)-1:0] row_taps;

  assign cnt_inc  = cnt + CNTW'(1);
  assign exec_len = CNTW'(nv_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      nv_q     <= '0;
      act_mode <= 1'b0;
      loaded   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      loaded <= loaded_n;
      if (state == S_IDLE && start) begin
        nv_q     <= num_vec;
        act_mode <= act_mode_in;
      end
    end
  end

  // A phase is waiting at entry only while its counter is still zero.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    loaded_n  = loaded;
    row0_inst = 2'b00;
    go        = (cnt != '0) || l0_ready;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          cnt_n = '0;
          // Tiles lose their kernels on reset, so the first job after one must load.
          if (load_en || !loaded)  state_n = S_LOAD;
          else if (num_vec == '0)  state_n = S_DRAIN;
          else                     state_n = S_EXEC;
        end
      end
      S_LOAD: begin
        if (go) begin
          row0_inst[INST_LOAD] = 1'b1;
          if (cnt_inc == COL_LEN) begin
            state_n  = S_GAP;
            cnt_n    = '0;
            loaded_n = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      S_GAP: begin
        if (go) begin
          if (cnt_inc == COL_LEN) begin
            state_n = (nv_q == '0) ? S_DRAIN : S_EXEC;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      S_EXEC: begin
        if (go) begin
          row0_inst[INST_EXEC] = 1'b1;
          if (cnt_inc == exec_len) begin
            state_n = S_DRAIN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      S_DRAIN: begin
        if (go) begin
          if (cnt_inc == DRAIN_LEN) begin
            state_n = S_DONE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  inst_skew #(.DEPTH(ROW-1), .WIDTH(2)) u_row_skew (
    .clk   (clk),
    .reset (reset),
    .din   (row0_inst),
    .taps  (row_taps)
  );

  assign inst_w = {row_taps, row0_inst};

  inst_skew #(.DEPTH(COL), .WIDTH(1)) u_col_skew (
    .clk   (clk),
    .reset (reset),
    .din   (inst_w[2*(ROW-1)+INST_EXEC]),
    .taps  (col_valid)
  );

  always_comb begin
    l0_rd = '0;
    for (int r = 0; r < ROW; r++) l0_rd[r] = |inst_w[2*r +: 2];
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Randomised job bench for mac_array_ctrl with a phase-timeline reference model and a scoreboard.
module tb_mac_array_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int CW  = 8;

  typedef struct packed {
    logic [2*ROW-1:0] inst;
    logic [ROW-1:0]   rd;
    logic [COL-1:0]   cv;
    logic             busy;
    logic             done;
    logic             act;
  } exp_t;

  logic            clk;
  logic            reset;
  logic            start;
  logic            load_en;
  logic [CW-1:0]   num_vec;
  logic            act_mode_in;
  logic            l0_ready;
  logic [2*ROW-1:0] inst_w;
  logic [ROW-1:0]  l0_rd;
  logic            act_mode;
  logic [COL-1:0]  col_valid;
  logic            busy;
  logic            done;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  logic [1:0] hist[$];
  logic loaded  = 1'b0;
  logic cur_act = 1'b0;

  mac_array_ctrl #(.ROW(ROW), .COL(COL), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .load_en     (load_en),
    .num_vec     (num_vec),
    .act_mode_in (act_mode_in),
    .l0_ready    (l0_ready),
    .inst_w      (inst_w),
    .l0_rd       (l0_rd),
    .act_mode    (act_mode),
    .col_valid   (col_valid),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, want);
    end
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("inst_w",    32'(inst_w),    32'(e.inst));
      chk("l0_rd",     32'(l0_rd),     32'(e.rd));
      chk("col_valid", 32'(col_valid), 32'(e.cv));
      chk("busy",      32'(busy),      32'(e.busy));
      chk("done",      32'(done),      32'(e.done));
      chk("act_mode",  32'(act_mode),  32'(e.act));
    end
  end

  // One cycle: drive inputs, record row-0 inst in the history, derive all outputs from it.
  task automatic step(input logic st, input logic ld, input logic [CW-1:0] nv, input logic am,
                      input logic rdy, input logic [1:0] code, input logic bsy, input logic dn);
    exp_t e;
    @(posedge clk);
    #1;
    start = st; load_en = ld; num_vec = nv; act_mode_in = am; l0_ready = rdy;
    hist.push_front(code);
    void'(hist.pop_back());
    e = '0;
    for (int r = 0; r < ROW; r++) begin
      e.inst[2*r +: 2] = hist[r];
      e.rd[r]          = |hist[r];
    end
    for (int c = 0; c < COL; c++) e.cv[c] = hist[ROW + c][1];
    e.busy = bsy;
    e.done = dn;
    e.act  = cur_act;
    exp_q.push_back(e);
  endtask

  task automatic busy_step(input logic rdy, input logic [1:0] code, input logic dn);
    step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), CW'($urandom_range(0, 255)),
         1'($urandom_range(0, 1)), rdy, code, 1'b1, dn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'($urandom_range(0, 1)), CW'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b00, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, 32'({inst_w, l0_rd, col_valid, busy, done, act_mode}), 32'd0);
  endtask

  task automatic do_reset();
    #6;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    for (int i = 0; i < hist.size(); i++) hist[i] = 2'b00;
    loaded  = 1'b0;
    cur_act = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0;
  endtask

  // Job timeline: per phase, stall cycles then its fixed length, then one DONE cycle.
  task automatic run_job(input logic ld, input int nv, input logic am,
                         input int sl, input int sg, input int se, input int sd, input int abort_at);
    int         len  [4];
    int         stl  [4];
    logic       used [4];
    logic [1:0] code [4];
    logic       eff;
    int         n;
    eff  = ld | !loaded;
    len  = '{COL, COL, nv, ROW + COL + 1};
    stl  = '{sl, sg, se, sd};
    used = '{eff, eff, (nv > 0), 1'b1};
    code = '{2'b01, 2'b00, 2'b10, 2'b00};
    step(1'b1, ld, CW'(nv), am, 1'($urandom_range(0, 1)), 2'b00, 1'b0, 1'b0);
    cur_act = am;
    n = 1;
    for (int p = 0; p < 4; p++) begin
      if (used[p]) begin
        for (int s = 0; s < stl[p]; s++) begin
          if (n == abort_at) begin do_reset(); return; end
          busy_step(1'b0, 2'b00, 1'b0);
          n++;
        end
        for (int i = 0; i < len[p]; i++) begin
          if (n == abort_at) begin do_reset(); return; end
          busy_step((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), code[p], 1'b0);
          n++;
        end
        if (p == 0) loaded = 1'b1;
      end
    end
    if (n == abort_at) begin do_reset(); return; end
    busy_step(1'($urandom_range(0, 1)), 2'b00, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 40; i++) hist.push_back(2'b00);
    reset = 1'b0; start = 1'b0; load_en = 1'b0; num_vec = '0; act_mode_in = 1'b0; l0_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    reset = 1'b1;

    run_job(1'b1, 4, 1'b1, 0, 0, 0, 0, -1);   // basic job
    idle(2);
    run_job(1'b0, 1, 1'b0, 0, 0, 0, 0, -1);   // skip load
    idle(2);
    run_job(1'b0, 0, 1'b1, 0, 0, 0, 0, -1);   // zero vectors
    idle(1);
    run_job(1'b1, 3, 1'b0, 0, 0, 5, 0, -1);   // stall at EXEC entry
    idle(2);
    run_job(1'b1, 6, 1'b1, 0, 0, 0, 0, 19);   // reset mid-EXEC
    idle(2);
    run_job(1'b0, 2, 1'b0, 0, 0, 0, 0, -1);   // load forced after reset
    idle(1);

    for (int j = 0; j < 25; j++) begin
      int ab;
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 40)) : -1;
      run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
              ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
              ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
              ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)), ab);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    @(posedge clk);
    #6;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
